// File: rtl/key_debounce.sv
// key_debounce
//   Turns a raw, bouncy, asynchronous key pin into a clean clk-synchronous
//   pressed level plus a separate long-press level.
//
//   Ports
//     clk        system clock, all state updates on the rising edge
//     rst        asynchronous active-high reset
//     key_in     raw key pin (asynchronous)
//     key_level  debounced pressed level, 1 = pressed (registered)
//     key_hold   long-press level, 1 = held >= LONG_CYCLES (registered)
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 200000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_WIDTH       = 28
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_hold
);

  // Synchronizer reset value is the released pin level, so a key held
  // through reset shows up as a fresh press once reset lifts.
  localparam logic                 REL_LVL   = (ACTIVE_LOW != 0);
  localparam logic                 DEB_ONE   = (DEBOUNCE_CYCLES == 1);
  localparam logic                 HOLD_EN   = (LONG_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE, PRESS_WAIT, PRESSED, HOLD, RELEASE_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   deb_q, deb_d;
  logic [CNT_WIDTH-1:0]   hold_q, hold_d;
  logic                   ret_hold_q, ret_hold_d;   // 1: release bounce returns to HOLD
  logic                   level_d, khold_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {SYNC_STAGES{REL_LVL}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
  end

  assign pressed = sync_q[SYNC_STAGES-1] ^ REL_LVL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      deb_q      <= '0;
      hold_q     <= '0;
      ret_hold_q <= 1'b0;
      key_level  <= 1'b0;
      key_hold   <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_q      <= deb_d;
      hold_q     <= hold_d;
      ret_hold_q <= ret_hold_d;
      key_level  <= level_d;
      key_hold   <= khold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    deb_d      = deb_q;
    hold_d     = hold_q;
    ret_hold_d = ret_hold_q;
    level_d    = key_level;
    khold_d    = key_hold;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          if (DEB_ONE) begin
            state_d = PRESSED;
            level_d = 1'b1;
            hold_d  = '0;
            deb_d   = '0;
          end else begin
            state_d = PRESS_WAIT;
            deb_d   = CNT_WIDTH'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          hold_d  = '0;
          deb_d   = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      PRESSED, HOLD: begin
        if (!pressed) begin
          // Release debounce; hold_cnt is frozen until we come back.
          if (DEB_ONE) begin
            state_d = IDLE;
            level_d = 1'b0;
            khold_d = 1'b0;
            deb_d   = '0;
          end else begin
            state_d    = RELEASE_WAIT;
            deb_d      = CNT_WIDTH'(1);
            ret_hold_d = (state_q == HOLD);
          end
        end else if (state_q == PRESSED) begin
          if (HOLD_EN && hold_q == HOLD_LAST) begin
            state_d = HOLD;
            khold_d = 1'b1;
          end else if (hold_q != CNT_MAX) begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = ret_hold_q ? HOLD : PRESSED;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          khold_d = 1'b0;
          deb_d   = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce. dut_a: active-low key, 4-cycle debounce,
// 10-cycle long press. dut_b: active-high key, hold detection disabled.
// Expected outputs are pushed to a queue as each step is driven and popped
// after the clock edge that should produce them.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_a = 1'b1;
  logic key_b = 1'b0;
  logic level_a, hold_a, level_b, hold_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic la;
    logic ha;
    logic lb;
    logic hb;
  } exp_t;

  exp_t exp_q[$];

  key_debounce #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10),
    .ACTIVE_LOW(1), .CNT_WIDTH(8)
  ) dut_a (
    .clk(clk), .rst(rst), .key_in(key_a), .key_level(level_a), .key_hold(hold_a)
  );

  key_debounce #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(0),
    .ACTIVE_LOW(0), .CNT_WIDTH(8)
  ) dut_b (
    .clk(clk), .rst(rst), .key_in(key_b), .key_level(level_b), .key_hold(hold_b)
  );

  always #5 clk = ~clk;

  task automatic push(input logic la, input logic ha, input logic lb);
    exp_t e;
    e.la = la; e.ha = ha; e.lb = lb; e.hb = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    exp_t got;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e   = exp_q.pop_front();
      got = {level_a, hold_a, level_b, hold_b};
      n_checks++;
      assert (got === e) else begin
        n_fail++;
        $error("FAIL %s: got {la,ha,lb,hb}=%b expected %b", tag, got, e);
      end
    end
  endtask

  // Drive keys for n edges; each edge must leave the given outputs.
  // Entered and left between edges (after the falling edge).
  task automatic cyc(input logic ka, input logic kb, input logic la,
                     input logic ha, input logic lb, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      key_a = ka;
      key_b = kb;
      push(la, ha, lb);
      @(posedge clk);
      #1;
      check_now(tag);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    push(0, 0, 0);
    check_now("reset");
    rst = 1'b0;
    cyc(1, 0, 0, 0, 0, 3, "idle");

    // 1. clean press: level on edge 6, release falls 6 edges later
    cyc(0, 0, 0, 0, 0, 5, "t1_press_wait");
    cyc(0, 0, 1, 0, 0, 4, "t1_pressed");
    cyc(1, 0, 1, 0, 0, 5, "t1_release_wait");
    cyc(1, 0, 0, 0, 0, 3, "t1_released");

    // 2. press bounce: 3 low, 1 high, then low; rise 6 edges after last fall
    cyc(0, 0, 0, 0, 0, 3, "t2_burst");
    cyc(1, 0, 0, 0, 0, 1, "t2_bounce");
    cyc(0, 0, 0, 0, 0, 5, "t2_press_wait");
    cyc(0, 0, 1, 0, 0, 1, "t2_rise");
    cyc(1, 0, 1, 0, 0, 5, "t2_release_wait");
    cyc(1, 0, 0, 0, 0, 3, "t2_released");

    // 3. long press: level edge 6, hold edge 16
    cyc(0, 0, 0, 0, 0, 5, "t3_press_wait");
    cyc(0, 0, 1, 0, 0, 10, "t3_pressed");
    cyc(0, 0, 1, 1, 0, 3, "t3_hold");

    // 4. release bounce in HOLD, then real release clears both at +6
    cyc(1, 0, 1, 1, 0, 2, "t4_bounce");
    cyc(0, 0, 1, 1, 0, 6, "t4_back_hold");
    cyc(1, 0, 1, 1, 0, 5, "t4_release_wait");
    cyc(1, 0, 0, 0, 0, 3, "t4_released");

    // 5. reset mid-hold, key kept down through reset
    cyc(0, 0, 0, 0, 0, 5, "t5_press_wait");
    cyc(0, 0, 1, 0, 0, 10, "t5_pressed");
    cyc(0, 0, 1, 1, 0, 2, "t5_hold");
    rst = 1'b1;
    #1;
    push(0, 0, 0);
    check_now("t5_async_reset");
    @(posedge clk);
    #1;
    push(0, 0, 0);
    check_now("t5_reset_held");
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 5, "t5_repress_wait");
    cyc(0, 0, 1, 0, 0, 1, "t5_repress");
    cyc(1, 0, 1, 0, 0, 5, "t5_release_wait");
    cyc(1, 0, 0, 0, 0, 2, "t5_released");

    // 6. active-high instance, hold disabled: 20 cycles high
    cyc(1, 1, 0, 0, 0, 5, "t6_press_wait");
    cyc(1, 1, 0, 0, 1, 15, "t6_pressed_no_hold");
    cyc(1, 0, 0, 0, 1, 5, "t6_release_wait");
    cyc(1, 0, 0, 0, 0, 3, "t6_released");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions a raw, bouncy, asynchronous button or switch input (e.g. the panel refresh key) into a clean, clock-synchronous level.
- key_level is the direct input of the level-to-pulse converter stage, which turns it into single-cycle edge pulses for the controller.
- Also reports a long-press condition as a separate level (key_hold), for alternate commands such as a full-panel clear.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flip-flops on key_in; must be 2 or more.
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to accept a press or a release; must be 1 or more. Default is 10 ms at 100 MHz.
- LONG_CYCLES, 200000000: clk cycles of confirmed press before key_hold asserts. 0 disables hold detection (key_hold stays 0).
- ACTIVE_LOW, 1: 1 means key_in = 0 is "pressed"; 0 means key_in = 1 is "pressed".
- CNT_WIDTH, 28: width of the internal counters; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  1  raw asynchronous key pin.
- key_level  output  1  debounced pressed level (1 = pressed), registered.
- key_hold  output  1  long-press level (1 = held for at least LONG_CYCLES), registered.

Behaviour:
- Reset (async assert; release is synchronous to clk):
  - key_level = 0, key_hold = 0, both counters = 0, FSM = IDLE.
  - Every synchronizer flop is loaded with the released value (1 if ACTIVE_LOW, else 0). A key held down through reset is therefore seen as a fresh press afterwards.
- Input conditioning:
  - key_in passes through an SYNC_STAGES-deep flop chain.
  - pressed = last sync stage XOR ACTIVE_LOW.
  - Only "pressed" feeds the FSM.
- FSM states: IDLE, PRESS_WAIT, PRESSED, HOLD, RELEASE_WAIT.
- IDLE:
  - pressed = 1 → PRESS_WAIT with deb_cnt = 1.
  - If DEBOUNCE_CYCLES = 1, go straight to PRESSED and set key_level = 1.
- PRESS_WAIT:
  - pressed = 0 → IDLE, deb_cnt = 0.
  - pressed = 1 and deb_cnt = DEBOUNCE_CYCLES-1 → PRESSED; key_level = 1; hold_cnt = 0.
  - Otherwise deb_cnt increments.
- PRESSED:
  - pressed = 1: hold_cnt increments.
  - When LONG_CYCLES ≠ 0 and hold_cnt reaches LONG_CYCLES-1 while pressed = 1 → HOLD, key_hold = 1.
  - pressed = 0 → RELEASE_WAIT, deb_cnt = 1, return state recorded as PRESSED.
- HOLD:
  - pressed = 0 → RELEASE_WAIT, deb_cnt = 1, return state recorded as HOLD.
  - hold_cnt saturates (no wrap).
- RELEASE_WAIT:
  - pressed = 1 → back to the recorded state, deb_cnt = 0. key_level and key_hold are unchanged; hold_cnt resumes from its paused value.
  - pressed = 0 and deb_cnt = DEBOUNCE_CYCLES-1 → IDLE; key_level = 0 and key_hold = 0 on the same edge.
  - Otherwise deb_cnt increments.
  - If DEBOUNCE_CYCLES = 1, release completes on the first low sample.
- Latency, with edge 1 = first clk edge that samples a changed key_in:
  - key_level changes on edge SYNC_STAGES + DEBOUNCE_CYCLES.
  - key_hold rises LONG_CYCLES edges after key_level rises, counting only edges in PRESSED with pressed = 1.
- Invariants:
  - key_hold = 1 implies key_level = 1.
  - Each output changes at most once per edge.
  - No combinational path from key_in to any output.
- Glitch handling: any bounce shorter than DEBOUNCE_CYCLES samples produces no output change.
- Reset mid-operation: rst asserted in any state forces the reset values immediately, without waiting for a clk edge.

Test Plan:
Bench parameters: SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4, LONG_CYCLES = 10, ACTIVE_LOW = 1 unless noted.
1. Clean press and release: after reset, drive key_in to 0 and hold → key_level rises on edge 6 and key_hold stays 0. Drive key_in back to 1 → key_level falls 6 edges later.
2. Press bounce: key_in low 3 cycles, high 1, then low permanently → no rise during the 3-cycle burst; key_level rises 6 edges after the final falling transition.
3. Long press: hold key_in = 0 → key_level rises at edge 6 and key_hold rises at edge 16. Release → both fall together 6 edges after release.
4. Release bounce in HOLD: key_in high for 2 cycles, then low → key_level and key_hold stay 1 and the FSM returns to HOLD. Then key_in high permanently → both clear at +6.
5. Reset mid-hold: assert rst asynchronously between edges while in HOLD → key_level and key_hold drop to 0 before the next edge. Release rst with key_in still 0 → new press accepted and key_level = 1 at edge 6.
6. ACTIVE_LOW = 0 instance with LONG_CYCLES = 0: key_in high for 20 cycles → key_level = 1 at edge 6 and key_hold never asserts.
